zero_pad_stream: RTL and testbench
==================================

# zero_pad_stream

Streaming zero-padding stage for the CNN datapath. It accepts an ifmap as a valid/ready beat stream of BW-bit Bfloat16 words and emits the padded ifmap, (IH+2P)×(IW+2P) per channel, as a registered valid/ready stream. Pad beats are generated internally without buffering the frame. It sits between the ifmap buffer reader and the convolution window generator, and replaces full-array combinational padding so large layers can be handled.

## Interface
- BW, 16, word width (Bfloat16)
- C, 3, channels per frame (≥1)
- IH, 32, ifmap rows (≥1)
- IW, 32, ifmap columns (≥1)
- P, 1, pad width on each side (≥0)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream word accepted when in_valid & in_ready
- in_data  in  BW  ifmap word; order: channel, then row, then column (column fastest)
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_data  out  BW  padded ifmap word, same ordering over the padded plane
- out_ch_last  out  1  marks the last word of a channel plane
- out_frame_last  out  1  marks the last word of the frame (final channel)
- frame_done  out  1  one-cycle pulse after the frame's last word is accepted

## Operation
- Output position counters: ch (0..C-1), row (0..IH+2P-1), col (0..IW+2P-1). They advance on every output-register load, col fastest, with wrap-around into row and then ch. After the last position they wrap to (0,0,0) and the next frame starts with no idle cycle.
- Interior: P ≤ row < IH+P and P ≤ col < IW+P. All other positions are pad.
- FSM, derived from the counters at the next load position:
  - S_PAD: output register loads the pad value. No input is consumed.
  - S_PASS: output register loads in_data and consumes one input word.
- Load enable: ld = ~out_valid | out_ready.
  - In S_PAD, load fires on ld.
  - In S_PASS, load fires on ld & in_valid.
- in_ready = S_PASS & ld & ~rst. It does not depend on in_valid.
- In S_PASS with in_valid low, out_valid drops to 0 once the current word is accepted. Counters hold.
- out_ch_last is high when the loaded position has row=IH+2P-1 and col=IW+2P-1. out_frame_last additionally requires ch=C-1.
- frame_done is high for the cycle after out_valid & out_ready & out_frame_last.
- P=0: every position is interior. The block acts as a one-register pipeline with the last-word flags.
- While out_valid & ~out_ready, out_data and both flags stay stable.
- Reset mid-frame: counters return to (0,0,0) and any partial frame is discarded. Upstream must restart at the first word of channel 0.
- Width: counters are $clog2(dim+1) bits. All comparisons are unsigned.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_ch_last=0, out_frame_last=0, frame_done=0
  - in_ready=0 while rst is high
  - counters=0, state=S_PAD if P>0, otherwise S_PASS
- Latency: an input word accepted at edge N appears on out_data after edge N (output register, 1 cycle).
- Throughput: 1 word per cycle when out_ready=1 and in_valid=1 in interior regions.
- Output beats per frame: C·(IH+2P)·(IW+2P). Input beats per frame: C·IH·IW.
- Simultaneous accept of the current word and load of the next word is allowed in the same cycle.

## Configuration
- ZERO_PAD_VALUE_EN
  - Defined: adds input port pad_value [BW-1:0]. It is sampled at the frame's first load position (ch=row=col=0) and used for all pad words of that frame. This supports non-zero padding, e.g. -inf ahead of max-pool.
  - Undefined: no port, and pad words are {BW{1'b0}}.

## Test plan
- C=1, IH=IW=2, P=1, in_data 1,2,3,4 with in_valid and out_ready held high:
  - Required output, 16 words: 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0.
  - out_ch_last and out_frame_last are high on word 16.
  - frame_done pulses the next cycle.
- C=2, IH=IW=3, P=1:
  - 50 output words and 18 input words.
  - out_ch_last on words 25 and 50; out_frame_last on word 50 only.
  - The second frame follows with no idle cycle.
- Backpressure on the first test: hold out_ready low for 3 cycles on word 6 (value 1). out_data=1 stays stable and in_ready=0 throughout. Output order is unchanged.
- Input starvation: drop in_valid for 4 cycles at word 7.
  - out_valid falls after word 6 is accepted.
  - Counters hold, and the stream resumes with value 2.
- P=0, C=1, IH=IW=2: output is 1,2,3,4, each word 1 cycle after its input is accepted; out_frame_last on value 4.
- Reset at output word 8 of the first test, then replay: output restarts from position (0,0,0), all outputs are 0 during reset, and the full 16-word sequence is correct. With ZERO_PAD_VALUE_EN defined and pad_value=16'hFF80, all 12 pad words equal FF80.

Source files
------------

// File: rtl/zero_pad_stream.sv
// zero_pad_stream: streams an ifmap out as its zero-padded (IH+2P)x(IW+2P) planes through one output register
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data upstream words (channel, row, column order);
// out_valid/out_ready/out_data padded words; out_ch_last / out_frame_last mark plane / frame ends;
// frame_done pulses the cycle after the frame's last word is accepted.
// Optional: define ZERO_PAD_VALUE_EN to add pad_value, sampled at each frame's first position and used for its pads.
module zero_pad_stream #(
  parameter int BW = 16,
  parameter int C  = 3,
  parameter int IH = 32,
  parameter int IW = 32,
  parameter int P  = 1
) (
  input  logic          clk,
  input  logic          rst,
`ifdef ZERO_PAD_VALUE_EN
  input  logic [BW-1:0] pad_value,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic          out_ch_last,
  output logic          out_frame_last,
  output logic          frame_done
);
  localparam int PH  = IH + 2 * P;
  localparam int PW  = IW + 2 * P;
  localparam int CHW = $clog2(C + 1);
  localparam int RW  = $clog2(PH + 1);
  localparam int CLW = $clog2(PW + 1);
  localparam logic [CHW-1:0] CH_MAX = CHW'(C - 1);
  localparam logic [RW-1:0]  R_MAX  = RW'(PH - 1);
  localparam logic [CLW-1:0] CL_MAX = CLW'(PW - 1);
  typedef enum logic {S_PAD, S_PASS} state_t;
  localparam state_t S_RST = (P > 0) ? S_PAD : S_PASS;
  state_t state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CLW-1:0] col_q, col_d;
  logic           out_valid_q, ch_last_q, frame_last_q, frame_done_q;
  logic [BW-1:0]  out_data_q, pad_word;
  logic           ld, fire, last_col, last_row, last_ch, interior_d;
  // Counters always hold the position of the next load, so the state follows from them.
  always_comb begin
    last_col = col_q == CL_MAX;
    last_row = row_q == R_MAX;
    last_ch  = ch_q == CH_MAX;
    col_d = !fire ? col_q : last_col ? '0 : col_q + 1'b1;
    row_d = !(fire && last_col) ? row_q : last_row ? '0 : row_q + 1'b1;
    ch_d  = !(fire && last_col && last_row) ? ch_q : last_ch ? '0 : ch_q + 1'b1;
  end
  generate
    if (P == 0) begin : g_nopad
      assign interior_d = 1'b1;
    end else begin : g_pad
      localparam logic [RW-1:0]  R_LO = RW'(P);
      localparam logic [RW-1:0]  R_HI = RW'(IH + P);
      localparam logic [CLW-1:0] C_LO = CLW'(P);
      localparam logic [CLW-1:0] C_HI = CLW'(IW + P);
      assign interior_d = row_d >= R_LO && row_d < R_HI && col_d >= C_LO && col_d < C_HI;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      ch_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end
  always_comb state_d = interior_d ? S_PASS : S_PAD;
`ifdef ZERO_PAD_VALUE_EN
  logic [BW-1:0] pad_q;
  logic          first;
  // The first position of a frame is itself a pad when P>0, so it uses pad_value directly.
  always_comb begin
    first    = ch_q == '0 && row_q == '0 && col_q == '0;
    pad_word = first ? pad_value : pad_q;
  end
  always_ff @(posedge clk) begin
    if (rst) pad_q <= '0;
    else if (fire && first) pad_q <= pad_value;
  end
`else
  always_comb pad_word = '0;
`endif
  // A pad load needs only room in the output register; a pass load also needs an input word.
  always_comb begin
    ld       = ~out_valid_q | out_ready;
    fire     = (state_q == S_PASS) ? ld & in_valid : ld;
    in_ready = (state_q == S_PASS) & ld & ~rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      ch_last_q    <= 1'b0;
      frame_last_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_valid_q & out_ready & frame_last_q;
      if (fire) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= (state_q == S_PASS) ? in_data : pad_word;
        ch_last_q    <= last_row & last_col;
        frame_last_q <= last_ch & last_row & last_col;
      end else if (ld) begin
        out_valid_q <= 1'b0;
      end
    end
  end
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_ch_last    = ch_last_q;
  assign out_frame_last = frame_last_q;
  assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_zero_pad_stream.sv
// tb_zero_pad_stream: directed checks of zero_pad_stream on three small configurations
module tb_zero_pad_stream;
`ifdef ZERO_PAD_VALUE_EN
  localparam logic [15:0] PADV = 16'hFF80;
  logic [15:0] pad_value = PADV;
`else
  localparam logic [15:0] PADV = 16'h0000;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  // a: C=1 2x2 P=1, b: C=2 3x3 P=1, z: C=1 2x2 P=0
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_ch_last, a_frame_last, a_frame_done;
  logic [15:0] a_in_data = 0, a_out_data;
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_ch_last, b_frame_last, b_frame_done;
  logic [15:0] b_in_data = 0, b_out_data;
  logic z_in_valid = 0, z_in_ready, z_out_valid, z_out_ready = 1, z_ch_last, z_frame_last, z_frame_done;
  logic [15:0] z_in_data = 0, z_out_data;
  zero_pad_stream #(.BW(16), .C(1), .IH(2), .IW(2), .P(1)) u_a (
    .clk(clk), .rst(rst),
`ifdef ZERO_PAD_VALUE_EN
    .pad_value(pad_value),
`endif
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ch_last(a_ch_last), .out_frame_last(a_frame_last), .frame_done(a_frame_done));
  zero_pad_stream #(.BW(16), .C(2), .IH(3), .IW(3), .P(1)) u_b (
    .clk(clk), .rst(rst),
`ifdef ZERO_PAD_VALUE_EN
    .pad_value(pad_value),
`endif
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ch_last(b_ch_last), .out_frame_last(b_frame_last), .frame_done(b_frame_done));
  zero_pad_stream #(.BW(16), .C(1), .IH(2), .IW(2), .P(0)) u_z (
    .clk(clk), .rst(rst),
`ifdef ZERO_PAD_VALUE_EN
    .pad_value(pad_value),
`endif
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .out_ch_last(z_ch_last), .out_frame_last(z_frame_last), .frame_done(z_frame_done));
  function automatic logic [15:0] exp_a(input int k);
    return k == 5 ? 16'd1 : k == 6 ? 16'd2 : k == 9 ? 16'd3 : k == 10 ? 16'd4 : PADV;
  endfunction
  function automatic logic [15:0] exp_b(input int k);
    int ch, r, c;
    ch = k / 25;
    r  = (k % 25) / 5;
    c  = k % 5;
    return (r >= 1 && r <= 3 && c >= 1 && c <= 3) ? 16'(ch * 9 + (r - 1) * 3 + c) : PADV;
  endfunction
  task automatic do_reset();
    rst = 1;
    {a_in_valid, b_in_valid, z_in_valid} = '0;
    {a_out_ready, b_out_ready, z_out_ready} = '1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    {a_out_ready, b_out_ready, z_out_ready} = '1;
    {a_in_valid, b_in_valid, z_in_valid} = '1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({a_out_valid, a_out_data, a_ch_last, a_frame_last, a_frame_done, a_in_ready} !== '0) begin
      errors++; $display("FAIL reset_a got v=%b d=%h cl=%b fl=%b fd=%b rdy=%b want all 0", a_out_valid, a_out_data, a_ch_last, a_frame_last, a_frame_done, a_in_ready);
    end
    checks++;
    if ({b_out_valid, b_out_data, b_ch_last, b_frame_last, b_frame_done, b_in_ready} !== '0) begin
      errors++; $display("FAIL reset_b got v=%b d=%h rdy=%b want all 0", b_out_valid, b_out_data, b_in_ready);
    end
    checks++;
    if ({z_out_valid, z_out_data, z_ch_last, z_frame_last, z_frame_done, z_in_ready} !== '0) begin
      errors++; $display("FAIL reset_z got v=%b d=%h rdy=%b want all 0", z_out_valid, z_out_data, z_in_ready);
    end
    {a_in_valid, b_in_valid, z_in_valid} = '0;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_basic();
    int no = 0, ni = 0;
    do_reset();
    a_in_valid = 1;
    a_out_ready = 1;
    for (int cyc = 0; cyc < 40 && no < 16; cyc++) begin
      a_in_data = 16'(ni % 4 + 1);
      #1;
      checks++;
      if (a_frame_done !== 1'b0) begin errors++; $display("FAIL basic_frame_done_early got %b want 0", a_frame_done); end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (a_out_data !== exp_a(no) || a_ch_last !== (no == 15) || a_frame_last !== (no == 15)) begin
          errors++; $display("FAIL basic_word%0d got d=%h cl=%b fl=%b want d=%h last=%b", no, a_out_data, a_ch_last, a_frame_last, exp_a(no), no == 15);
        end
        no++;
      end
      if (a_in_valid && a_in_ready) ni++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (no != 16) begin errors++; $display("FAIL basic_timeout got %0d words want 16", no); end
    checks++;
    if (a_frame_done !== 1'b1) begin errors++; $display("FAIL basic_frame_done got %b want 1", a_frame_done); end
    checks++;
    if (ni != 4) begin errors++; $display("FAIL basic_inputs got %0d want 4", ni); end
    a_in_valid = 0;
  endtask
  task automatic test_backpressure();
    int no = 0, ni = 0, st = 0;
    do_reset();
    a_in_valid = 1;
    for (int cyc = 0; cyc < 50 && no < 16; cyc++) begin
      a_in_data = 16'(ni % 4 + 1);
      a_out_ready = !(no == 5 && a_out_valid && st < 3);
      #1;
      if (!a_out_ready) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 16'd1 || a_in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_stall%0d got v=%b d=%h rdy=%b want v=1 d=0001 rdy=0", st, a_out_valid, a_out_data, a_in_ready);
        end
        st++;
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (a_out_data !== exp_a(no) || a_frame_last !== (no == 15)) begin
          errors++; $display("FAIL bp_word%0d got d=%h fl=%b want d=%h", no, a_out_data, a_frame_last, exp_a(no));
        end
        no++;
      end
      if (a_in_valid && a_in_ready) ni++;
      @(negedge clk);
    end
    checks++;
    if (no != 16 || st != 3) begin errors++; $display("FAIL bp_timeout got words=%0d stalls=%0d want 16 3", no, st); end
    a_in_valid = 0;
    a_out_ready = 1;
  endtask
  task automatic test_starvation();
    int no = 0, ni = 0, g = 0;
    do_reset();
    a_out_ready = 1;
    for (int cyc = 0; cyc < 50 && no < 16; cyc++) begin
      a_in_data = 16'(ni % 4 + 1);
      a_in_valid = !(ni == 1 && g < 4);
      #1;
      if (!a_in_valid) begin
        if (g > 0) begin
          checks++;
          if (a_out_valid !== 1'b0) begin errors++; $display("FAIL starve_gap%0d got out_valid=%b want 0", g, a_out_valid); end
        end
        g++;
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (a_out_data !== exp_a(no)) begin
          errors++; $display("FAIL starve_word%0d got %h want %h", no, a_out_data, exp_a(no));
        end
        no++;
      end
      if (a_in_valid && a_in_ready) ni++;
      @(negedge clk);
    end
    checks++;
    if (no != 16 || g != 4) begin errors++; $display("FAIL starve_timeout got words=%0d gap=%0d want 16 4", no, g); end
    a_in_valid = 0;
  endtask
  task automatic test_two_frames();
    int no = 0, ni = 0;
    do_reset();
    b_in_valid = 1;
    b_out_ready = 1;
    for (int cyc = 0; cyc < 120 && no < 50; cyc++) begin
      b_in_data = 16'(ni % 18 + 1);
      #1;
      if (no > 0) begin
        checks++;
        if (b_out_valid !== 1'b1) begin errors++; $display("FAIL two_bubble at word%0d got out_valid=%b want 1", no, b_out_valid); end
      end
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (b_out_data !== exp_b(no) || b_ch_last !== (no == 24 || no == 49) || b_frame_last !== (no == 49)) begin
          errors++; $display("FAIL two_word%0d got d=%h cl=%b fl=%b want d=%h cl=%b fl=%b", no, b_out_data, b_ch_last, b_frame_last, exp_b(no), no == 24 || no == 49, no == 49);
        end
        no++;
      end
      if (b_in_valid && b_in_ready) ni++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (no != 50 || ni != 18) begin errors++; $display("FAIL two_counts got out=%0d in=%0d want 50 18", no, ni); end
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== PADV || b_ch_last !== 1'b0 || b_frame_done !== 1'b1) begin
      errors++; $display("FAIL two_next_frame got v=%b d=%h cl=%b fd=%b want v=1 d=%h cl=0 fd=1", b_out_valid, b_out_data, b_ch_last, b_frame_done, PADV);
    end
    b_in_valid = 0;
  endtask
  task automatic test_p0();
    int no = 0, ni = 0;
    logic pend = 0;
    logic [15:0] pv = 0;
    do_reset();
    z_out_ready = 1;
    for (int cyc = 0; cyc < 20 && no < 4; cyc++) begin
      z_in_valid = ni < 4;
      z_in_data = 16'(ni + 1);
      #1;
      if (pend) begin
        checks++;
        if (z_out_valid !== 1'b1 || z_out_data !== pv) begin
          errors++; $display("FAIL p0_latency got v=%b d=%h want v=1 d=%h", z_out_valid, z_out_data, pv);
        end
        pend = 0;
      end
      if (z_out_valid && z_out_ready) begin
        checks++;
        if (z_out_data !== 16'(no + 1) || z_frame_last !== (no == 3) || z_ch_last !== (no == 3)) begin
          errors++; $display("FAIL p0_word%0d got d=%h fl=%b cl=%b want d=%0d last=%b", no, z_out_data, z_frame_last, z_ch_last, no + 1, no == 3);
        end
        no++;
      end
      if (z_in_valid && z_in_ready) begin
        pend = 1;
        pv = z_in_data;
        ni++;
      end
      @(negedge clk);
    end
    checks++;
    if (no != 4) begin errors++; $display("FAIL p0_timeout got %0d words want 4", no); end
    z_in_valid = 0;
  endtask
  task automatic test_reset_mid();
    int no = 0, ni = 0, pads = 0;
    do_reset();
    a_in_valid = 1;
    a_out_ready = 1;
    for (int cyc = 0; cyc < 30 && no < 7; cyc++) begin
      a_in_data = 16'(ni % 4 + 1);
      #1;
      if (a_out_valid && a_out_ready) no++;
      if (a_in_valid && a_in_ready) ni++;
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    #1;
    checks++;
    if ({a_out_valid, a_out_data, a_ch_last, a_frame_last, a_frame_done, a_in_ready} !== '0) begin
      errors++; $display("FAIL rmid_in_reset got v=%b d=%h cl=%b fl=%b fd=%b rdy=%b want all 0", a_out_valid, a_out_data, a_ch_last, a_frame_last, a_frame_done, a_in_ready);
    end
    @(negedge clk);
    rst = 0;
    no = 0;
    ni = 0;
    for (int cyc = 0; cyc < 40 && no < 16; cyc++) begin
      a_in_data = 16'(ni % 4 + 1);
      #1;
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (a_out_data !== exp_a(no) || a_ch_last !== (no == 15) || a_frame_last !== (no == 15)) begin
          errors++; $display("FAIL rmid_word%0d got d=%h cl=%b fl=%b want d=%h last=%b", no, a_out_data, a_ch_last, a_frame_last, exp_a(no), no == 15);
        end
        if (a_out_data === PADV && exp_a(no) === PADV) pads++;
        no++;
      end
      if (a_in_valid && a_in_ready) ni++;
      @(negedge clk);
    end
    checks++;
    if (no != 16 || pads != 12) begin errors++; $display("FAIL rmid_replay got words=%0d pads=%0d want 16 12", no, pads); end
    a_in_valid = 0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_two_frames();
    test_p0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
